lsu_ahb_sbuf: RTL
=================

# lsu_ahb_sbuf

Parametrised load/store unit with a posted store buffer, driving the core's AHB-Lite data-side master port. It sits in the EX stage behind the address adder and replaces the single-transfer LSU. Stores retire into a DEPTH-entry FIFO so the pipeline need not stall on them. Loads may bypass buffered stores to other words and return a sign- or zero-extended write-back.

## Interface
Parameters:
- XLEN, 32: data/address width; only 32 is supported.
- SB_DEPTH, 4: store-buffer entries; power of two, ≥2.
- RF_IDX_WIDTH, 5: register-file index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory request present.
- req_ready  out  1  request accepted this cycle.
  - Store: ready = (count < SB_DEPTH).
  - Load: ready = !ld_pend.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word.
- req_unsigned  in  1  load zero-extends.
- req_addr  in  XLEN  effective address.
- req_wdata  in  XLEN  store data (rs2).
- req_rd  in  RF_IDX_WIDTH  load destination.
- ld_wb_en  out  1  one-cycle load write-back pulse.
- ld_wb_rd  out  RF_IDX_WIDTH  load destination register.
- ld_wb_data  out  XLEN  load write-back data.
- misalign  out  1  pulse; request misaligned, dropped.
- bus_err  out  1  pulse; transfer got an HRESP error.
- sb_empty  out  1  no buffered store and bus idle; gates fence.
- d_haddr  out  32  AHB address.
- d_htrans  out  2  AHB transfer type.
- d_hwrite  out  1  AHB write.
- d_hsize  out  3  AHB size.
- d_hburst  out  3  AHB burst type.
- d_hprot  out  4  AHB protection.
- d_hwdata  out  32  AHB write data.
- d_hrdata  in  32  AHB read data.
- d_hready  in  1  AHB ready.
- d_hresp  in  1  AHB response.

## Operation
- **Accept:** a request is accepted on the edge where req_valid & req_ready.
- **Misalignment:** half with addr[0] set, or word with addr[1:0] ≠ 0.
  - Accepted but never enqueued or issued.
  - misalign pulses the following cycle.
- **Stores:** push {addr, size, wdata} into the FIFO.
  - Push and pop in the same cycle are legal, including when full; ready still uses the pre-pop count.
- **Loads:** captured into a single load slot (ld_pend = 1).
- **Hazard:** the pending load conflicts if any valid FIFO entry has entry.addr[31:2] == load.addr[31:2].
- **Issue arbitration** (state IDLE only):
  - Pending, non-conflicting load wins.
  - Otherwise the FIFO head store issues.
  - A conflicting load waits until every matching store has drained.
- **FSM IDLE → ADDR → DATA → IDLE:**
  - IDLE: htrans = 00.
  - ADDR: htrans = 10 (NONSEQ); haddr, hwrite, hsize = {1'b0, size} driven from registers; stay until d_hready = 1.
  - DATA: htrans = 00; store data on hwdata; stay until d_hready = 1.
  - Exactly one outstanding transfer at any time.
- **Constant AHB fields:** hburst = 000, hprot = 0011.
- **Store lane replication:** byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- **Load extraction:** select the lane by addr[1:0], then sign- or zero-extend.
- **Write-back suppression:** rd == 0 performs the bus read but ld_wb_en stays 0.
- **Error** (d_hresp = 1 when DATA completes):
  - bus_err pulses.
  - A store entry is popped and discarded.
  - A load clears ld_pend with no write-back.
- **Store pop:** the FIFO pops when the store's DATA phase completes.
- **sb_empty** = (count == 0) & !ld_pend & (state == IDLE).

## Timing
- **Reset values:**
  - FIFO count, ld_pend, and all pulses are 0; state = IDLE.
  - All AHB outputs are 0, htrans = IDLE, hprot = 0011.
  - sb_empty = 1; req_ready = 1.
- **Reset mid-transfer:** the transfer is abandoned and buffered stores are lost.
- **Load latency, zero-wait bus:**
  - Accept edge T.
  - ADDR in cycle T+1.
  - DATA in cycle T+2.
  - ld_wb_en registered high in cycle T+3.
  - Each wait state adds one cycle.
- **Store latency:** a store into an empty FIFO with the bus idle drives NONSEQ in cycle T+1.
- **Pulse timing:** ld_wb_en, misalign, and bus_err are single-cycle registered pulses.
- **Combinational paths:** req_ready has no combinational path from d_hready. It depends only on req_store and registered state.

## Structure
- **Package lsu_pkg:** size encodings, HTRANS_IDLE/NONSEQ constants, FSM state enum, and a function lane_extract(rdata, off, size, uns).
- **Sub-module sbuf_fifo:** SB_DEPTH-deep FIFO with head output and a per-entry word-address match vector, OR-reduced to hazard.
- **Top level:** FSM, load slot, lane logic, and pulses.

## Test plan
- **Zero-wait load:** word load from 0x100, hrdata 0x8000_00F0, rd = 5 → ld_wb_en in T+3, data 0x8000_00F0, rd 5.
- **Byte loads:** lb at 0x103, hrdata 0x8000_0000 → 0xFFFF_FF80; lbu at the same address → 0x0000_0080.
- **Buffer fill:** five stores back-to-back, hready held low → req_ready drops after four accepts; after release, the stores appear in order with hwdata lanes replicated.
- **Hazard vs bypass:**
  - Store to 0x200, then load of 0x202 → load issues only after the store's DATA phase.
  - Load of 0x300 instead → load issues before the buffered store.
- **Misalign and error:**
  - lh at 0x101 → misalign pulse, no bus activity.
  - Store with hresp = 1 → bus_err pulse, FIFO count decrements.
- **Reset mid-transfer:** rst_n low during DATA with 3 stores buffered → htrans = 00, sb_empty = 1, req_ready = 1 while reset is asserted.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and lane helpers for the data-side LSU.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } sb_entry_t;

    // Pick the addressed lane out of the bus word, then sign/zero extend.
    function automatic logic [31:0] lane_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
            SZ_HALF: r = {{16{h[15] & ~uns}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [31:0] wdata,
                                                   input logic [1:0]  size);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{wdata[7:0]}};
            SZ_HALF: r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_ahb_sbuf_if.sv
// AHB-Lite data-side bus bundle between the LSU (master) and the fabric (slave).
// Latency: wires only.
// Backpressure: d_hready stalls the master in both address and data phases.
interface lsu_ahb_sbuf_if;
    logic [31:0] d_haddr;
    logic [1:0]  d_htrans;
    logic        d_hwrite;
    logic [2:0]  d_hsize;
    logic [2:0]  d_hburst;
    logic [3:0]  d_hprot;
    logic [31:0] d_hwdata;
    logic [31:0] d_hrdata;
    logic        d_hready;
    logic        d_hresp;

    modport master (
        output d_haddr, d_htrans, d_hwrite, d_hsize, d_hburst, d_hprot, d_hwdata,
        input  d_hrdata, d_hready, d_hresp
    );

    modport slave (
        input  d_haddr, d_htrans, d_hwrite, d_hsize, d_hburst, d_hprot, d_hwdata,
        output d_hrdata, d_hready, d_hresp
    );
endinterface

// File: rtl/sbuf_fifo.sv
// Posted-store FIFO with head peek and word-address hazard match across live entries.
// Latency: push visible at head one cycle later; match vector is combinational.
// Backpressure: caller must not push when count == DEPTH; pop only when non-empty.
module sbuf_fifo
    import lsu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  sb_entry_t   push_dat,
    input  logic        pop,
    output sb_entry_t   head_dat,
    output logic [PW:0] count,
    input  logic [29:0] match_addr,
    output logic        hazard
);

    sb_entry_t        mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    off;
    logic [DEPTH-1:0] match_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        match_vec = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            match_vec[i] = ({1'b0, off} < count) && (mem[i].addr[31:2] == match_addr);
        end
    end

    assign hazard = |match_vec;

endmodule

// File: rtl/lsu_ahb_sbuf.sv
// Load/store unit with posted store buffer driving a single-outstanding AHB-Lite master.
// Latency: load accept T -> ADDR T+1 -> DATA T+2 -> write-back T+3 (+1 per wait state).
// Backpressure: stores stall when the buffer is full, loads while the load slot is busy.
module lsu_ahb_sbuf
    import lsu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SB_DEPTH     = 4,
    parameter int RF_IDX_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_store,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [XLEN-1:0]         req_addr,
    input  logic [XLEN-1:0]         req_wdata,
    input  logic [RF_IDX_WIDTH-1:0] req_rd,
    output logic                    ld_wb_en,
    output logic [RF_IDX_WIDTH-1:0] ld_wb_rd,
    output logic [XLEN-1:0]         ld_wb_data,
    output logic                    misalign,
    output logic                    bus_err,
    output logic                    sb_empty,
    lsu_ahb_sbuf_if.master          ahb
);

    localparam int CW = $clog2(SB_DEPTH) + 1;

    state_e                  state_q, state_d;
    logic [CW-1:0]           sb_count;
    sb_entry_t               sb_head;
    logic                    hazard;

    logic                    ld_pend;
    logic [31:0]             ld_addr;
    logic [1:0]              ld_size;
    logic                    ld_uns;
    logic [RF_IDX_WIDTH-1:0] ld_rd;

    logic [31:0]             haddr_q;
    logic [31:0]             hwdata_q;
    logic                    hwrite_q;
    logic [1:0]              hsize_q;

    logic accept, req_misalign, sb_push, sb_pop, ld_capture;
    logic ld_issue, st_issue, data_done;

    // Ready looks only at registered state so d_hready never reaches it.
    assign req_ready    = req_store ? (sb_count < CW'(SB_DEPTH)) : !ld_pend;
    assign req_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign accept       = req_valid && req_ready;
    assign sb_push      = accept && req_store && !req_misalign;
    assign ld_capture   = accept && !req_store && !req_misalign;
    assign data_done    = (state_q == ST_DATA) && ahb.d_hready;
    assign sb_pop       = data_done && hwrite_q;

    sbuf_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (sb_push),
        .push_dat   ('{addr: req_addr, size: req_size, wdata: req_wdata}),
        .pop        (sb_pop),
        .head_dat   (sb_head),
        .count      (sb_count),
        .match_addr (ld_addr[31:2]),
        .hazard     (hazard)
    );

    // A load may overtake buffered stores unless one of them targets its word.
    always_comb begin
        state_d  = state_q;
        ld_issue = 1'b0;
        st_issue = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_pend && !hazard) begin
                    ld_issue = 1'b1;
                    state_d  = ST_ADDR;
                end else if (sb_count != '0) begin
                    st_issue = 1'b1;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: if (ahb.d_hready) state_d = ST_DATA;
            ST_DATA: if (ahb.d_hready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            hwrite_q   <= 1'b0;
            hsize_q    <= '0;
            ld_pend    <= 1'b0;
            ld_addr    <= '0;
            ld_size    <= '0;
            ld_uns     <= 1'b0;
            ld_rd      <= '0;
            ld_wb_en   <= 1'b0;
            ld_wb_rd   <= '0;
            ld_wb_data <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_issue) begin
                haddr_q  <= ld_addr;
                hwrite_q <= 1'b0;
                hsize_q  <= ld_size;
            end else if (st_issue) begin
                haddr_q  <= sb_head.addr;
                hwrite_q <= 1'b1;
                hsize_q  <= sb_head.size;
                hwdata_q <= lane_replicate(sb_head.wdata, sb_head.size);
            end

            if (ld_capture) begin
                ld_pend <= 1'b1;
                ld_addr <= req_addr;
                ld_size <= req_size;
                ld_uns  <= req_unsigned;
                ld_rd   <= req_rd;
            end else if (data_done && !hwrite_q) begin
                ld_pend <= 1'b0;
            end

            ld_wb_en <= data_done && !hwrite_q && !ahb.d_hresp && (ld_rd != '0);
            if (data_done && !hwrite_q) begin
                ld_wb_rd   <= ld_rd;
                ld_wb_data <= lane_extract(ahb.d_hrdata, ld_addr[1:0], ld_size, ld_uns);
            end
            misalign <= accept && req_misalign;
            bus_err  <= data_done && ahb.d_hresp;
        end
    end

    assign ahb.d_htrans = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb.d_haddr  = haddr_q;
    assign ahb.d_hwrite = hwrite_q;
    assign ahb.d_hsize  = {1'b0, hsize_q};
    assign ahb.d_hwdata = hwdata_q;
    assign ahb.d_hburst = HBURST_SINGLE;
    assign ahb.d_hprot  = HPROT_DATA;

    assign sb_empty = (sb_count == '0) && !ld_pend && (state_q == ST_IDLE);

endmodule
